// File: rtl/bsg_manycore_remote_req_ctrl_pkg.sv
// Packet-level types shared between the manycore endpoint and its request initiators.
// The packet struct is width-parameterised, so it is provided as a declaration macro.
package bsg_manycore_remote_req_ctrl_pkg;

  localparam int unsigned PacketOpWidth = 2;

  typedef enum logic [PacketOpWidth-1:0] {
    OpLoad  = 2'b00,
    OpStore = 2'b01
  } bsg_manycore_packet_op_e;

  // Type of a packet coming back on the endpoint's returned_* interface.
  typedef enum logic [1:0] {
    RetCredit = 2'b00,
    RetData   = 2'b01
  } bsg_manycore_return_packet_type_e;

endpackage

`define BSG_MANYCORE_PACKET_WIDTH(addr_w, data_w, x_w, y_w) \
  ((addr_w) + 2 + ((data_w) >> 3) + (data_w) + 2 * (x_w) + 2 * (y_w))

`define DECLARE_BSG_MANYCORE_PACKET_S(addr_w, data_w, x_w, y_w) \
  typedef struct packed { \
    logic [(addr_w)-1:0]          addr; \
    bsg_manycore_packet_op_e      op; \
    logic [((data_w) >> 3)-1:0]   op_ex; \
    logic [(data_w)-1:0]          payload; \
    logic [(y_w)-1:0]             src_y_cord; \
    logic [(x_w)-1:0]             src_x_cord; \
    logic [(y_w)-1:0]             y_cord; \
    logic [(x_w)-1:0]             x_cord; \
  } bsg_manycore_packet_s

// File: rtl/bsg_manycore_load_tag_fifo.sv
// Circular FIFO of local load tags, one entry per outstanding remote load.
// A push is accepted while full if an entry is popped in the same cycle.
module bsg_manycore_load_tag_fifo #(
  parameter int unsigned els_p   = 4,
  parameter int unsigned width_p = 5
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         pop_i,
  output logic [width_p-1:0]           data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int unsigned ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned count_width_lp = $clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0]   last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [count_width_lp-1:0] els_lp      = count_width_lp'(els_p);

  logic [width_p-1:0]        mem_q [els_p];
  logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
  logic [count_width_lp-1:0] count_q, count_d;
  logic                      push_eff, pop_eff;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == els_lp);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign pop_eff  = pop_i & ~empty_o;
  assign push_eff = push_i & (~full_o | pop_eff);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_eff) begin
      rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push_eff) begin
      wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
    end
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/bsg_manycore_remote_req_ctrl.sv
// Initiator-side remote load/store controller: formats packets, tracks credits and load tags.
// Define BSG_MANYCORE_REQ_FENCE_EN to add fence_i / fence_busy_o request fencing.
module bsg_manycore_remote_req_ctrl
  import bsg_manycore_remote_req_ctrl_pkg::*;
#(
  parameter int unsigned x_cord_width_p    = 4,
  parameter int unsigned y_cord_width_p    = 4,
  parameter int unsigned data_width_p      = 32,
  parameter int unsigned addr_width_p      = 32,
  parameter int unsigned max_out_credits_p = 16,
  parameter int unsigned load_els_p        = 4,
  parameter int unsigned tag_width_p       = 5
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   req_v_i,
  output logic                                   req_ready_o,
  input  logic                                   req_we_i,
  input  logic [addr_width_p-1:0]                req_addr_i,
  input  logic [data_width_p-1:0]                req_data_i,
  input  logic [(data_width_p>>3)-1:0]           req_mask_i,
  input  logic [x_cord_width_p-1:0]              req_x_i,
  input  logic [y_cord_width_p-1:0]              req_y_i,
  input  logic [tag_width_p-1:0]                 req_tag_i,
  input  logic [x_cord_width_p-1:0]              my_x_i,
  input  logic [y_cord_width_p-1:0]              my_y_i,
`ifdef BSG_MANYCORE_REQ_FENCE_EN
  input  logic                                   fence_i,
  output logic                                   fence_busy_o,
`endif
  output logic                                   out_v_o,
  output logic [`BSG_MANYCORE_PACKET_WIDTH(addr_width_p, data_width_p, x_cord_width_p,
                                           y_cord_width_p)-1:0] out_packet_o,
  input  logic                                   out_ready_i,
  input  logic                                   returned_credit_v_i,
  input  logic                                   returned_v_i,
  input  logic [data_width_p-1:0]                returned_data_i,
  output logic                                   resp_v_o,
  output logic [data_width_p-1:0]                resp_data_o,
  output logic [tag_width_p-1:0]                 resp_tag_o,
  output logic [$clog2(max_out_credits_p+1)-1:0] out_credits_o,
  output logic [$clog2(load_els_p+1)-1:0]        loads_pending_o
);

  `DECLARE_BSG_MANYCORE_PACKET_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);

  localparam int unsigned credit_width_lp = $clog2(max_out_credits_p + 1);
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  logic                       slot_v_q, slot_v_d;
  bsg_manycore_packet_s       slot_q, slot_d;
  logic [credit_width_lp-1:0] credits_q, credits_d;
  logic [x_cord_width_p-1:0]  last_x_q, last_x_d;
  logic [y_cord_width_p-1:0]  last_y_q, last_y_d;
  logic                       resp_v_q;
  logic [data_width_p-1:0]    resp_data_q;
  logic [tag_width_p-1:0]     resp_tag_q;

  logic                       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [tag_width_p-1:0]     fifo_tag;
  logic                       slot_free, have_credit, same_tile, load_ok, fence_stall, accept;
  bsg_manycore_return_packet_type_e ret_type;

  assign ret_type = returned_v_i ? RetData : RetCredit;
  assign fifo_pop = (ret_type == RetData);

`ifdef BSG_MANYCORE_REQ_FENCE_EN
  assign fence_busy_o = fence_i & ((credits_q != max_credits_lp) | slot_v_q);
  assign fence_stall  = fence_busy_o;
`else
  assign fence_stall  = 1'b0;
`endif

  // Loads to a new tile wait for every older load so responses come back in order.
  assign slot_free   = ~slot_v_q | out_ready_i;
  assign have_credit = (credits_q != '0);
  assign same_tile   = (req_x_i == last_x_q) & (req_y_i == last_y_q);
  assign load_ok     = req_we_i | ((~fifo_full | fifo_pop) & (fifo_empty | same_tile));
  assign req_ready_o = slot_free & have_credit & load_ok & ~fence_stall;
  assign accept      = req_v_i & req_ready_o;
  assign fifo_push   = accept & ~req_we_i;

  always_comb begin
    slot_d   = slot_q;
    slot_v_d = slot_v_q & ~out_ready_i;
    last_x_d = last_x_q;
    last_y_d = last_y_q;
    if (accept) begin
      slot_v_d           = 1'b1;
      slot_d.addr        = req_addr_i;
      slot_d.op          = req_we_i ? OpStore : OpLoad;
      slot_d.op_ex       = req_we_i ? req_mask_i : '0;
      slot_d.payload     = req_data_i;
      slot_d.src_y_cord  = my_y_i;
      slot_d.src_x_cord  = my_x_i;
      slot_d.y_cord      = req_y_i;
      slot_d.x_cord      = req_x_i;
      if (!req_we_i) begin
        last_x_d = req_x_i;
        last_y_d = req_y_i;
      end
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({accept, returned_credit_v_i})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   if (credits_q != max_credits_lp) credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot_v_q    <= 1'b0;
      slot_q      <= '0;
      credits_q   <= max_credits_lp;
      last_x_q    <= '0;
      last_y_q    <= '0;
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      slot_v_q  <= slot_v_d;
      slot_q    <= slot_d;
      credits_q <= credits_d;
      last_x_q  <= last_x_d;
      last_y_q  <= last_y_d;
      resp_v_q  <= fifo_pop;
      if (fifo_pop) begin
        resp_data_q <= returned_data_i;
        resp_tag_q  <= fifo_tag;
      end
    end
  end

  bsg_manycore_load_tag_fifo #(
    .els_p   (load_els_p),
    .width_p (tag_width_p)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .data_i  (req_tag_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (loads_pending_o)
  );

  assign out_v_o       = slot_v_q;
  assign out_packet_o  = slot_q;
  assign out_credits_o = credits_q;
  assign resp_v_o      = resp_v_q;
  assign resp_data_o   = resp_data_q;
  assign resp_tag_o    = resp_tag_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && returned_v_i && fifo_empty) begin
      $error("returned load data with no load outstanding");
      $finish;
    end
    if (!reset_i && returned_credit_v_i && (credits_q == max_credits_lp)) begin
      $error("credit returned while already holding all credits");
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_bsg_manycore_remote_req_ctrl.sv
// Bench for bsg_manycore_remote_req_ctrl: directed scenarios then random traffic vs a model.
module tb_bsg_manycore_remote_req_ctrl;
  import bsg_manycore_remote_req_ctrl_pkg::*;

  localparam int unsigned XW = 4, YW = 4, DW = 32, AW = 32, TW = 5;
  localparam int unsigned MaxCred = 16, LoadEls = 4;
  localparam int unsigned MW = DW >> 3;
  localparam int unsigned PW = `BSG_MANYCORE_PACKET_WIDTH(AW, DW, XW, YW);

  `DECLARE_BSG_MANYCORE_PACKET_S(AW, DW, XW, YW);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, req_v_i, req_ready_o, req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_data_i, returned_data_i, resp_data_o;
  logic [MW-1:0] req_mask_i;
  logic [XW-1:0] req_x_i, my_x_i;
  logic [YW-1:0] req_y_i, my_y_i;
  logic [TW-1:0] req_tag_i, resp_tag_o;
  logic          out_v_o, out_ready_i, returned_credit_v_i, returned_v_i, resp_v_o;
  logic [PW-1:0] out_packet_o;
  logic [4:0]    out_credits_o;
  logic [2:0]    loads_pending_o;

  bsg_manycore_remote_req_ctrl #(
    .x_cord_width_p    (XW),
    .y_cord_width_p    (YW),
    .data_width_p      (DW),
    .addr_width_p      (AW),
    .max_out_credits_p (MaxCred),
    .load_els_p        (LoadEls),
    .tag_width_p       (TW)
  ) dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .req_v_i             (req_v_i),
    .req_ready_o         (req_ready_o),
    .req_we_i            (req_we_i),
    .req_addr_i          (req_addr_i),
    .req_data_i          (req_data_i),
    .req_mask_i          (req_mask_i),
    .req_x_i             (req_x_i),
    .req_y_i             (req_y_i),
    .req_tag_i           (req_tag_i),
    .my_x_i              (my_x_i),
    .my_y_i              (my_y_i),
    .out_v_o             (out_v_o),
    .out_packet_o        (out_packet_o),
    .out_ready_i         (out_ready_i),
    .returned_credit_v_i (returned_credit_v_i),
    .returned_v_i        (returned_v_i),
    .returned_data_i     (returned_data_i),
    .resp_v_o            (resp_v_o),
    .resp_data_o         (resp_data_o),
    .resp_tag_o          (resp_tag_o),
    .out_credits_o       (out_credits_o),
    .loads_pending_o     (loads_pending_o)
  );

  // Reference model state
  int                   m_credits;
  logic [TW-1:0]        m_tags[$];
  logic [XW-1:0]        m_last_x;
  logic [YW-1:0]        m_last_y;
  logic                 m_slot_v;
  bsg_manycore_packet_s m_slot;
  logic                 m_resp_v;
  logic [DW-1:0]        m_resp_data;
  logic [TW-1:0]        m_resp_tag;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("out_v", 128'(out_v_o), 128'(m_slot_v));
    if (m_slot_v) chk("out_packet", 128'(out_packet_o), 128'(m_slot));
    chk("credits", 128'(out_credits_o), 128'(m_credits));
    chk("loads_pending", 128'(loads_pending_o), 128'(m_tags.size()));
    chk("resp_v", 128'(resp_v_o), 128'(m_resp_v));
    if (m_resp_v) begin
      chk("resp_data", 128'(resp_data_o), 128'(m_resp_data));
      chk("resp_tag", 128'(resp_tag_o), 128'(m_resp_tag));
    end
  endtask

  task automatic idle_inputs();
    req_v_i             = 1'b0;
    req_we_i            = 1'b1;
    returned_credit_v_i = 1'b0;
    returned_v_i        = 1'b0;
    returned_data_i     = '0;
    out_ready_i         = 1'b1;
  endtask

  task automatic set_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [MW-1:0] mask, input logic [XW-1:0] x,
                         input logic [YW-1:0] y, input logic [TW-1:0] tag);
    req_v_i    = 1'b1;
    req_we_i   = we;
    req_addr_i = addr;
    req_data_i = data;
    req_mask_i = mask;
    req_x_i    = x;
    req_y_i    = y;
    req_tag_i  = tag;
  endtask

  task automatic set_ret(input logic cred, input logic data_v, input logic [DW-1:0] data);
    returned_credit_v_i = cred;
    returned_v_i        = data_v;
    returned_data_i     = data;
  endtask

  // One clock: check acceptance against the model, advance the model, check the outputs.
  task automatic step();
    logic exp_ready, acc;
    bit   tile_ok, room_ok;
    #1;
    room_ok   = (m_tags.size() < LoadEls) || returned_v_i;
    tile_ok   = (m_tags.size() == 0) || (req_x_i == m_last_x && req_y_i == m_last_y);
    exp_ready = (!m_slot_v || out_ready_i) && (m_credits > 0) && (req_we_i || (room_ok && tile_ok));
    chk("req_ready", 128'(req_ready_o), 128'(exp_ready));
    acc = req_v_i && exp_ready;
    @(posedge clk);
    #1;
    m_resp_v = returned_v_i;
    if (returned_v_i) begin
      m_resp_data = returned_data_i;
      m_resp_tag  = m_tags.pop_front();
    end
    if (acc && !req_we_i) begin
      m_tags.push_back(req_tag_i);
      m_last_x = req_x_i;
      m_last_y = req_y_i;
    end
    m_credits = m_credits - (acc ? 1 : 0) + (returned_credit_v_i ? 1 : 0);
    if (m_credits > MaxCred) m_credits = MaxCred;
    if (acc) begin
      m_slot_v            = 1'b1;
      m_slot.addr         = req_addr_i;
      m_slot.op           = req_we_i ? OpStore : OpLoad;
      m_slot.op_ex        = req_we_i ? req_mask_i : '0;
      m_slot.payload      = req_data_i;
      m_slot.src_y_cord   = my_y_i;
      m_slot.src_x_cord   = my_x_i;
      m_slot.y_cord       = req_y_i;
      m_slot.x_cord       = req_x_i;
    end else if (out_ready_i) begin
      m_slot_v = 1'b0;
    end
    chk_state();
  endtask

  task automatic do_reset(input int cycles);
    reset_i = 1'b1;
    idle_inputs();
    repeat (cycles) @(posedge clk);
    #1;
    reset_i   = 1'b0;
    m_credits = MaxCred;
    m_tags.delete();
    m_slot_v  = 1'b0;
    m_resp_v  = 1'b0;
    chk_state();
  endtask

  // Returns every credit and load still outstanding in the model.
  task automatic drain_all();
    req_v_i = 1'b0;
    for (int i = 0; i < 64 && m_credits < MaxCred; i++) begin
      if (m_tags.size() > 0) set_ret(1'b1, 1'b1, DW'($urandom()));
      else                   set_ret(1'b1, 1'b0, '0);
      step();
    end
    set_ret(1'b0, 1'b0, '0);
  endtask

  initial begin
    my_x_i     = 4'd3;
    my_y_i     = 4'd0;
    req_addr_i = '0;
    req_data_i = '0;
    req_mask_i = '0;
    req_x_i    = '0;
    req_y_i    = '0;
    req_tag_i  = '0;
    do_reset(3);

    // Single store and its credit coming back
    set_req(1'b1, 32'h40, 32'hDEADBEEF, 4'b1111, 4'd2, 4'd1, 5'd0);
    step();
    chk("store_credits_15", 128'(out_credits_o), 128'(15));
    req_v_i = 1'b0;
    step();
    set_ret(1'b1, 1'b0, '0);
    step();
    chk("store_credits_back", 128'(out_credits_o), 128'(16));
    set_ret(1'b0, 1'b0, '0);

    // Exhaust all credits with stores, then one return re-enables acceptance
    for (int i = 0; i < 16; i++) begin
      set_req(1'b1, AW'(i * 4), DW'($urandom()), 4'(i), 4'd2, 4'd1, 5'd0);
      step();
    end
    step();
    set_ret(1'b1, 1'b0, '0);
    step();
    set_ret(1'b0, 1'b0, '0);
    step();
    drain_all();

    // Three loads to one tile, returned in order
    set_req(1'b0, 32'h100, '0, '0, 4'd1, 4'd1, 5'd3);
    step();
    req_tag_i = 5'd7;
    step();
    req_tag_i = 5'd9;
    step();
    req_v_i = 1'b0;
    set_ret(1'b1, 1'b1, 32'hAAAA0001);
    step();
    set_ret(1'b1, 1'b1, 32'hBBBB0002);
    step();
    set_ret(1'b1, 1'b1, 32'hCCCC0003);
    step();
    set_ret(1'b0, 1'b0, '0);
    step();

    // Load to a different tile waits for the pending load to return
    set_req(1'b0, 32'h200, '0, '0, 4'd1, 4'd1, 5'd4);
    step();
    set_req(1'b0, 32'h300, '0, '0, 4'd2, 4'd1, 5'd5);
    step();
    step();
    set_ret(1'b1, 1'b1, 32'h12345678);
    step();
    set_ret(1'b0, 1'b0, '0);
    step();
    drain_all();

    // Fill the tag FIFO; fifth load stalls, then push and pop together
    for (int i = 0; i < 4; i++) begin
      set_req(1'b0, AW'(32'h400 + i), '0, '0, 4'd1, 4'd1, TW'(10 + i));
      step();
    end
    req_tag_i = 5'd14;
    step();
    set_ret(1'b1, 1'b1, 32'h0F0F0F0F);
    step();
    chk("pending_full_swap", 128'(loads_pending_o), 128'(4));
    drain_all();

    // Back-pressure holds the packet, then reset mid-stall
    out_ready_i = 1'b0;
    set_req(1'b1, 32'h500, 32'hCAFEF00D, 4'b0101, 4'd2, 4'd2, 5'd0);
    step();
    set_req(1'b1, 32'h504, 32'h11111111, 4'b1111, 4'd2, 4'd2, 5'd0);
    step();
    step();
    do_reset(1);
    chk("reset_credits", 128'(out_credits_o), 128'(16));

    // Random traffic; returns kept legal so the credit/tag invariants hold
    for (int i = 0; i < 400; i++) begin
      set_req(1'($urandom()), AW'($urandom()), DW'($urandom()), MW'($urandom()),
              XW'($urandom_range(1, 2)), 4'd1, TW'($urandom()));
      req_v_i     = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      if (m_tags.size() > 0 && $urandom_range(0, 2) == 0)
        set_ret(1'b1, 1'b1, DW'($urandom()));
      else if ((m_credits + m_tags.size() < MaxCred) && $urandom_range(0, 2) == 0)
        set_ret(1'b1, 1'b0, '0);
      else
        set_ret(1'b0, 1'b0, '0);
      step();
    end
    idle_inputs();
    drain_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
